// File: rtl/score_req_arbiter.sv
// score_req_arbiter: serialises four player score posts onto one tracker.
// Define SCOREARB_RR_EN for round-robin; default is fixed priority (p0 high).
module score_req_arbiter #(
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 2,
  parameter int INIT_CYCLES = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  req_i,
  input  logic [19:0] score_bus_i,
  input  logic        trk_personal_win_i,
  input  logic        trk_global_winner_i,
  output logic        score_req_o,
  output logic [1:0]  player_id_o,
  output logic [4:0]  score_o,
  output logic [3:0]  ack_o,
  output logic [1:0]  result_id_o,
  output logic        win_personal_o,
  output logic        win_global_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_INIT, S_IDLE, S_HOLD, S_GAP
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  pend_q, pend_d;
  logic [4:0]  sc_q [4];
  logic [4:0]  sc_d [4];
  logic        sreq_q, sreq_d;
  logic [1:0]  pid_q, pid_d;
  logic [4:0]  score_q, score_d;
  logic [3:0]  ack_q, ack_d;
  logic [1:0]  rid_q, rid_d;
  logic        wp_q, wp_d;
  logic        wg_q, wg_d;
  logic        busy_q, busy_d;
  logic [1:0]  win;

`ifdef SCOREARB_RR_EN
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  idx;
  logic        found;

  always_comb begin
    win   = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && pend_q[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (pend_q[k]) win = 2'(k);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    sc_d    = sc_q;
    sreq_d  = sreq_q;
    pid_d   = pid_q;
    score_d = score_q;
    ack_d   = '0;
    rid_d   = rid_q;
    wp_d    = wp_q;
    wg_d    = wg_q;
`ifdef SCOREARB_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      S_INIT: begin
        if (cnt_q == 5'(INIT_CYCLES - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_IDLE: begin
        if (|pend_q) begin
          sreq_d      = 1'b1;
          pid_d       = win;
          score_d     = sc_q[win];
          pend_d[win] = 1'b0;
`ifdef SCOREARB_RR_EN
          ptr_d       = win;
`endif
          state_d     = S_HOLD;
          cnt_d       = '0;
        end
      end
      S_HOLD: begin
        if (cnt_q == 5'(HOLD_CYCLES - 1)) begin
          sreq_d       = 1'b0;
          wp_d         = trk_personal_win_i;
          wg_d         = trk_global_winner_i;
          rid_d        = pid_q;
          ack_d[pid_q] = 1'b1;
          state_d      = S_GAP;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 5'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
    endcase
    // Capture after the grant clear so a same-edge post stays pending.
    for (int i = 0; i < 4; i++) begin
      if (req_i[i]) begin
        pend_d[i] = 1'b1;
        sc_d[i]   = score_bus_i[5*i +: 5];
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < 4; i++) sc_q[i] <= '0;
      sreq_q  <= 1'b0;
      pid_q   <= '0;
      score_q <= '0;
      ack_q   <= '0;
      rid_q   <= '0;
      wp_q    <= 1'b0;
      wg_q    <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      sc_q    <= sc_d;
      sreq_q  <= sreq_d;
      pid_q   <= pid_d;
      score_q <= score_d;
      ack_q   <= ack_d;
      rid_q   <= rid_d;
      wp_q    <= wp_d;
      wg_q    <= wg_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SCOREARB_RR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 2'd3;
    else         ptr_q <= ptr_d;
  end
`endif

  assign score_req_o    = sreq_q;
  assign player_id_o    = pid_q;
  assign score_o        = score_q;
  assign ack_o          = ack_q;
  assign result_id_o    = rid_q;
  assign win_personal_o = wp_q;
  assign win_global_o   = wg_q;
  assign busy_o         = busy_q;

endmodule

// File: doc/score_req_arbiter.md
# score_req_arbiter

Shares the single-request score tracker between four player ports. Each port posts a 5-bit score with a one-cycle request pulse. The arbiter queues one pending score per player and serialises the requests onto the tracker's level-sensitive ScoreReq/PlayerID/Score interface. It returns each result as a per-player acknowledge carrying the tracker's PersonalWin and GlobalWinner flags. It sits between the player input logic and the score tracker, and its reset is tied to the tracker's reset.

## Interface
- HOLD_CYCLES, 16: cycles ScoreReq is held high per grant. Must be ≥ 15, the tracker's worst-case request-to-idle path.
- GAP_CYCLES, 2: minimum cycles ScoreReq is held low between grants. Must be ≥ 2.
- INIT_CYCLES, 10: cycles after reset release before the first grant. Covers the tracker's 8-entry RAM clear.
- Clk  in  1  single clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Req  in  4  per-player score-post pulse, bit i = player i.
- ScoreBus  in  20  player i score on bits [5i+4:5i]. Sampled only in the Req cycle.
- ScoreReq  out  1  to tracker ScoreReq.
- PlayerID  out  2  to tracker PlayerID.
- Score  out  5  to tracker Score.
- TrkPersonalWin  in  1  from tracker PersonalWin.
- TrkGlobalWinner  in  1  from tracker GlobalWinner.
- Ack  out  4  one-cycle completion pulse, at most one bit set.
- ResultID  out  2  player the current Ack/result belongs to.
- WinPersonal  out  1  sampled TrkPersonalWin, valid with Ack and held until the next Ack.
- WinGlobal  out  1  sampled TrkGlobalWinner, valid with Ack and held until the next Ack.
- Busy  out  1  high in every state except IDLE.

## Operation
- All outputs are registered.
- Reset values:
  - ScoreReq=0, PlayerID=0, Score=0.
  - Ack=0, ResultID=0, WinPersonal=0, WinGlobal=0.
  - Busy=1 (state INIT).
  - Pending=0, pointer=3, all counters=0.
- Capture: on an edge where Req[i]=1, Pending[i] is set and ScoreReg[i] is loaded from ScoreBus slice i.
  - A new Req[i] while Pending[i]=1 overwrites ScoreReg[i]. Latest score wins; no extra grant is issued.
  - Req[i] on the same edge as a grant of player i clears nothing. Pending[i] stays set with the new score, for a later grant.
- States:
  - INIT: count INIT_CYCLES, then go to IDLE.
  - IDLE: if Pending≠0, select winner w, then:
    - load PlayerID=w, Score=ScoreReg[w], ScoreReq=1.
    - clear Pending[w] and set pointer=w.
    - go to HOLD. Otherwise stay in IDLE.
  - HOLD: count HOLD_CYCLES. On the final count edge:
    - ScoreReq=0.
    - WinPersonal and WinGlobal take the tracker flags; ResultID=PlayerID.
    - Ack[PlayerID]=1 for that one cycle.
    - go to GAP.
  - GAP: Ack returns to 0. Count GAP_CYCLES, then go to IDLE.
- Selection: round-robin starting at pointer+1 mod 4 (see Configuration).
- Counters are 5 bits wide, with no wrap inside a phase.
- PlayerID and Score are stable for the whole HOLD phase.

## Timing
- Req pulse at edge t, arbiter IDLE: ScoreReq=1 from edge t+1.
- With no contention, Ack is asserted at edge t+1+HOLD_CYCLES.
- Grant-to-grant period is HOLD_CYCLES+GAP_CYCLES+1 cycles (19 at defaults).
- Worst-case wait for a pending player is 3 full periods.
- Reset asserted mid-HOLD: ScoreReq drops asynchronously, no Ack is produced, and all pending scores are lost.
- Req during INIT: captured; the first grant comes at the INIT→IDLE exit.
- Simultaneous Req on all four ports: each player is served exactly once, in selection order.

## Configuration
- Macro SCOREARB_RR_EN.
- Defined: round-robin selection; the search starts at pointer+1, with pointer = last granted player.
- Undefined: fixed priority, player 0 highest and player 3 lowest; the pointer register is not built.

## Test plan
- Reset release, then Req=0001 with score 12 at cycle 2: no ScoreReq before INIT ends. ScoreReq high with PlayerID=0, Score=12 for exactly 16 cycles. Ack=0001 follows with WinPersonal=1.
- Req=1111 in one cycle, scores 3/7/9/5, RR build: grants in order 0,1,2,3, each 19 cycles apart. Four Acks with ResultID 0..3.
- Same stimulus, non-RR build, with Req[0] re-pulsed every period: player 0 is re-granted each period while players 1–3 wait.
- Req[2] score 4, then score 20 before its grant: one grant only, with Score=20.
- Rst pulled low 5 cycles into HOLD: ScoreReq=0 immediately, Ack never pulses, Busy=1. After release, INIT is rerun.
- Req[1] pulsed on the edge its own grant is issued: a second grant for player 1 follows after GAP with the newly captured score.
